// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback controller: entry layout and age compare.
package wb_pkg;
  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 32;
  // Storage width for sequence stamps; the live width is set per instance from DEPTH.
  localparam int unsigned SEQ_W = 8;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [SEQ_W-1:0] seq;
  } wb_entry_t;

  // A is older than B when (A - B) modulo 2^sw has its MSB set.
  function automatic logic seq_older(input logic [SEQ_W-1:0] a,
                                     input logic [SEQ_W-1:0] b,
                                     input int unsigned sw);
    logic [SEQ_W-1:0] d;
    d = a - b;
    return |(d & (SEQ_W'(1) << (sw - 1)));
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Single-channel entry FIFO; head is presented combinationally from the read pointer.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [PW:0]   wr_q;
  logic [PW:0]   rd_q;

  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/rf_writeback_ctrl.sv
// Dual-port register-file writeback: ALU FIFO feeds port 1, load FIFO feeds port 2.
// Optional statistics counters are built when WB_STATS_EN is defined.
module rf_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned DW    = WB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          we2,
  output logic [AW-1:0] waddr2,
  output logic [DW-1:0] wdata2,
  output logic          busy,
  output logic [31:0]   stat_wr,
  output logic [31:0]   stat_conf
);
  localparam int unsigned SW = $clog2(2 * DEPTH) + 1;

  wb_entry_t     alu_in, ld_in, alu_head, ld_head;
  logic          alu_full, alu_empty, ld_full, ld_empty;
  logic          alu_push, ld_push, alu_pop, ld_pop;
  logic          conflict, alu_older;
  logic [SW-1:0] seq_q, seq_d;

  assign alu_ready = !alu_full;
  assign ld_ready  = !ld_full;
  assign alu_push  = alu_valid && !alu_full;
  assign ld_push   = ld_valid && !ld_full;
  assign busy      = !alu_empty || !ld_empty;

  // Same-cycle enqueue: ALU takes seq, load takes seq+1, so the ALU entry is older.
  always_comb begin
    alu_in = '{addr: alu_addr, data: alu_data, seq: SEQ_W'(seq_q)};
    ld_in  = '{addr: ld_addr, data: ld_data, seq: SEQ_W'(seq_q + SW'(alu_push))};
    seq_d  = seq_q + SW'(alu_push) + SW'(ld_push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push_i(alu_push), .pop_i(alu_pop), .din_i(alu_in),
    .full_o(alu_full), .empty_o(alu_empty), .head_o(alu_head)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clk(clk), .rst(rst), .push_i(ld_push), .pop_i(ld_pop), .din_i(ld_in),
    .full_o(ld_full), .empty_o(ld_empty), .head_o(ld_head)
  );

  always_comb begin
    conflict  = !alu_empty && !ld_empty && (alu_head.addr == ld_head.addr);
    alu_older = seq_older(alu_head.seq, ld_head.seq, SW);
    alu_pop   = !alu_empty && (!conflict || alu_older);
    ld_pop    = !ld_empty && (!conflict || !alu_older);
    we        = alu_pop;
    waddr     = alu_pop ? alu_head.addr : '0;
    wdata     = alu_pop ? alu_head.data : '0;
    we2       = ld_pop;
    waddr2    = ld_pop ? ld_head.addr : '0;
    wdata2    = ld_pop ? ld_head.data : '0;
  end

`ifdef WB_STATS_EN
  logic [31:0] stat_wr_q, stat_conf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_q   <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_wr_q   <= stat_wr_q + 32'(alu_pop) + 32'(ld_pop);
      stat_conf_q <= stat_conf_q + 32'(conflict);
    end
  end

  assign stat_wr   = stat_wr_q;
  assign stat_conf = stat_conf_q;
`else
  assign stat_wr   = '0;
  assign stat_conf = '0;
`endif
endmodule
